// File: rtl/trig_pkg.sv
// Shared types and widths for the sine/cosine sequencing datapath.
package trig_pkg;

    localparam int FLOAT_W    = 32;
    localparam int ANGLE_FX_W = 16;
    localparam int FLIP_W     = 3;
    localparam int STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE        = 3'd0,
        ST_NORM_REQ    = 3'd1,
        ST_NORM_WAIT   = 3'd2,
        ST_CORDIC_REQ  = 3'd3,
        ST_CORDIC_WAIT = 3'd4,
        ST_RESULT      = 3'd5
    } state_t;

    function automatic logic is_wait_state(input state_t s);
        return (s == ST_NORM_WAIT) || (s == ST_CORDIC_WAIT);
    endfunction

endpackage

// File: rtl/trig_sequencer.sv
// Single-operation controller: normalizer -> cordic -> result handshake.
// Optional watchdog on the WAIT states is enabled with SEQ_WATCHDOG_EN.
module trig_sequencer
    import trig_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 200
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_start,
    input  logic [FLOAT_W-1:0]    cmd_angle,
    input  logic                  cmd_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  norm_start,
    output logic [FLOAT_W-1:0]    norm_angle,
    input  logic                  norm_valid,
    output logic                  norm_recived,
    input  logic [FLIP_W-1:0]     norm_flip,
    input  logic [ANGLE_FX_W-1:0] norm_angle_fx,
    output logic                  cordic_start,
    output logic [ANGLE_FX_W-1:0] cordic_angle,
    input  logic                  cordic_done,
    input  logic [ANGLE_FX_W-1:0] cordic_sin,
    input  logic [ANGLE_FX_W-1:0] cordic_cos,
    output logic [ANGLE_FX_W-1:0] res_sin,
    output logic [ANGLE_FX_W-1:0] res_cos,
    output logic [FLIP_W-1:0]     res_flip
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_wd_fire;
    logic                    w_busy_nxt;
    logic                    w_norm_start_nxt;
    logic                    w_handoff_nxt;
    logic                    w_done_nxt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_norm_start;
    logic                    r_norm_recived;
    logic                    r_cordic_start;
    logic [FLOAT_W-1:0]      r_norm_angle;
    logic [ANGLE_FX_W-1:0]   r_cordic_angle;
    logic [FLIP_W-1:0]       r_flip;
    logic [ANGLE_FX_W-1:0]   r_res_sin;
    logic [ANGLE_FX_W-1:0]   r_res_cos;
    logic [FLIP_W-1:0]       r_res_flip;

`ifdef SEQ_WATCHDOG_EN
    logic [CNT_W-1:0]        r_wd_cnt;
    logic                    r_err;
    logic                    w_timeout;

    assign w_timeout = (r_wd_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
    // A valid/done arriving on the timeout cycle still wins over the watchdog.
    assign w_wd_fire = w_timeout &&
                       (((r_state == ST_NORM_WAIT) && !norm_valid) ||
                        ((r_state == ST_CORDIC_WAIT) && !cordic_done));

    // Watchdog counter: cleared on WAIT entry, saturating increment while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt <= {CNT_W{1'b0}};
        end else if (is_wait_state(w_state_nxt) && (w_state_nxt != r_state)) begin
            r_wd_cnt <= {CNT_W{1'b0}};
        end else if (is_wait_state(r_state) && (r_wd_cnt != {CNT_W{1'b1}})) begin
            r_wd_cnt <= r_wd_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Error flag: set by a watchdog expiry, held through RESULT until ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_wd_fire || (r_err && (w_state_nxt == ST_RESULT));
        end
    end

    assign err = r_err;
`else
    assign w_wd_fire = 1'b0;
    assign err       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:        w_state_nxt = cmd_start ? ST_NORM_REQ : ST_IDLE;
            ST_NORM_REQ:    w_state_nxt = ST_NORM_WAIT;
            ST_NORM_WAIT: begin
                if (norm_valid)     w_state_nxt = ST_CORDIC_REQ;
                else if (w_wd_fire) w_state_nxt = ST_RESULT;
                else                w_state_nxt = ST_NORM_WAIT;
            end
            ST_CORDIC_REQ:  w_state_nxt = ST_CORDIC_WAIT;
            ST_CORDIC_WAIT: begin
                if (cordic_done)    w_state_nxt = ST_RESULT;
                else if (w_wd_fire) w_state_nxt = ST_RESULT;
                else                w_state_nxt = ST_CORDIC_WAIT;
            end
            ST_RESULT:      w_state_nxt = cmd_ack ? ST_IDLE : ST_RESULT;
            default:        w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every control output is a flop.
    always_comb begin
        w_busy_nxt       = (w_state_nxt != ST_IDLE);
        w_norm_start_nxt = (w_state_nxt == ST_NORM_REQ);
        w_handoff_nxt    = (w_state_nxt == ST_CORDIC_REQ);
        w_done_nxt       = (w_state_nxt == ST_RESULT);
    end

    // Registered control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_norm_start   <= 1'b0;
            r_norm_recived <= 1'b0;
            r_cordic_start <= 1'b0;
        end else begin
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_norm_start   <= w_norm_start_nxt;
            r_norm_recived <= w_handoff_nxt;
            r_cordic_start <= w_handoff_nxt;
        end
    end

    // Datapath latches; a timeout leaves the previous result untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_norm_angle   <= {FLOAT_W{1'b0}};
            r_cordic_angle <= {ANGLE_FX_W{1'b0}};
            r_flip         <= {FLIP_W{1'b0}};
            r_res_sin      <= {ANGLE_FX_W{1'b0}};
            r_res_cos      <= {ANGLE_FX_W{1'b0}};
            r_res_flip     <= {FLIP_W{1'b0}};
        end else begin
            if ((r_state == ST_IDLE) && cmd_start) begin
                r_norm_angle <= cmd_angle;
            end
            if ((r_state == ST_NORM_WAIT) && norm_valid) begin
                r_cordic_angle <= norm_angle_fx;
                r_flip         <= norm_flip;
            end
            if ((r_state == ST_CORDIC_WAIT) && cordic_done) begin
                r_res_sin  <= cordic_sin;
                r_res_cos  <= cordic_cos;
                r_res_flip <= r_flip;
            end
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign norm_start   = r_norm_start;
    assign norm_recived = r_norm_recived;
    assign cordic_start = r_cordic_start;
    assign norm_angle   = r_norm_angle;
    assign cordic_angle = r_cordic_angle;
    assign res_sin      = r_res_sin;
    assign res_cos      = r_res_cos;
    assign res_flip     = r_res_flip;

endmodule

// File: tb/tb_trig_sequencer.sv
// Directed self-checking bench for trig_sequencer (default and SEQ_WATCHDOG_EN builds).
module tb_trig_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_start;
    logic [31:0] cmd_angle;
    logic        cmd_ack;
    logic        busy;
    logic        done;
    logic        err;
    logic        norm_start;
    logic [31:0] norm_angle;
    logic        norm_valid;
    logic        norm_recived;
    logic [2:0]  norm_flip;
    logic [15:0] norm_angle_fx;
    logic        cordic_start;
    logic [15:0] cordic_angle;
    logic        cordic_done;
    logic [15:0] cordic_sin;
    logic [15:0] cordic_cos;
    logic [15:0] res_sin;
    logic [15:0] res_cos;
    logic [2:0]  res_flip;

    int checks   = 0;
    int failures = 0;
    int ns_cnt   = 0;
    int nr_cnt   = 0;
    int cs_cnt   = 0;
    int snap_ns;
    int snap_nr;
    int snap_cs;

    always #5 clk = ~clk;

    trig_sequencer #(.CNT_W(8), .TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .rst(rst),
        .cmd_start(cmd_start), .cmd_angle(cmd_angle), .cmd_ack(cmd_ack),
        .busy(busy), .done(done), .err(err),
        .norm_start(norm_start), .norm_angle(norm_angle), .norm_valid(norm_valid),
        .norm_recived(norm_recived), .norm_flip(norm_flip), .norm_angle_fx(norm_angle_fx),
        .cordic_start(cordic_start), .cordic_angle(cordic_angle), .cordic_done(cordic_done),
        .cordic_sin(cordic_sin), .cordic_cos(cordic_cos),
        .res_sin(res_sin), .res_cos(res_cos), .res_flip(res_flip)
    );

    // Pulse counters for the three one-cycle strobes.
    always @(posedge clk) begin
        if (norm_start)   ns_cnt++;
        if (norm_recived) nr_cnt++;
        if (cordic_start) cs_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full zero-wait operation ending in RESULT (not acknowledged).
    task automatic run_op(input string tag, input logic [31:0] ang, input logic [2:0] flip,
                          input logic [15:0] fx, input logic [15:0] sn, input logic [15:0] cs);
        cmd_angle = ang;
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_norm_start"}, 32'(norm_start), 32'd1);
        chk({tag, "_norm_angle"}, norm_angle, ang);
        norm_valid    = 1'b1;
        norm_flip     = flip;
        norm_angle_fx = fx;
        step();
        chk({tag, "_norm_start_off"}, 32'(norm_start), 32'd0);
        chk({tag, "_nr_early"}, 32'(norm_recived), 32'd0);
        step();
        norm_valid = 1'b0;
        chk({tag, "_norm_recived"}, 32'(norm_recived), 32'd1);
        chk({tag, "_cordic_start"}, 32'(cordic_start), 32'd1);
        chk({tag, "_cordic_angle"}, 32'(cordic_angle), 32'(fx));
        step();
        chk({tag, "_cordic_start_off"}, 32'(cordic_start), 32'd0);
        chk({tag, "_done_early"}, 32'(done), 32'd0);
        cordic_done = 1'b1;
        cordic_sin  = sn;
        cordic_cos  = cs;
        step();
        cordic_done = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_res_sin"}, 32'(res_sin), 32'(sn));
        chk({tag, "_res_cos"}, 32'(res_cos), 32'(cs));
        chk({tag, "_res_flip"}, 32'(res_flip), 32'(flip));
    endtask

    task automatic ack_op(input string tag);
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        chk({tag, "_ack_done"}, 32'(done), 32'd0);
        chk({tag, "_ack_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ack_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        rst = 1'b0; cmd_start = 1'b0; cmd_angle = 32'h0; cmd_ack = 1'b0;
        norm_valid = 1'b0; norm_flip = 3'b0; norm_angle_fx = 16'h0;
        cordic_done = 1'b0; cordic_sin = 16'h0; cordic_cos = 16'h0;
        step(); step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_norm_start", 32'(norm_start), 32'd0);
        chk("rst_norm_angle", norm_angle, 32'h0);
        chk("rst_res_cos", 32'(res_cos), 32'h0);
        rst = 1'b1;
        step();

        // Nominal 90 degrees, with pulse counting.
        snap_ns = ns_cnt; snap_nr = nr_cnt; snap_cs = cs_cnt;
        run_op("nom", 32'h42B4_0000, 3'b111, 16'h0000, 16'h0000, 16'h4000);
        step();
        chk("nom_hold_done", 32'(done), 32'd1);
        chk("nom_hold_cos", 32'(res_cos), 32'h4000);
        ack_op("nom");
        chk("nom_ns_pulses", 32'(ns_cnt - snap_ns), 32'd1);
        chk("nom_nr_pulses", 32'(nr_cnt - snap_nr), 32'd1);
        chk("nom_cs_pulses", 32'(cs_cnt - snap_cs), 32'd1);

        // Start pulsed during CORDIC_WAIT is ignored.
        cmd_angle = 32'h4120_0000; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0; norm_valid = 1'b1; norm_flip = 3'b000; norm_angle_fx = 16'h0E39;
        step(); step();
        norm_valid = 1'b0;
        step();
        snap_ns = ns_cnt;
        cmd_angle = 32'h1234_5678; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_norm_start", 32'(norm_start), 32'd0);
        chk("ign_norm_angle", norm_angle, 32'h4120_0000);
        step();
        chk("ign_norm_start2", 32'(norm_start), 32'd0);
        cordic_done = 1'b1; cordic_sin = 16'h0B1C; cordic_cos = 16'h3F07;
        step();
        cordic_done = 1'b0;
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_res_sin", 32'(res_sin), 32'h0B1C);
        chk("ign_ns_pulses", 32'(ns_cnt - snap_ns), 32'd0);
        ack_op("ign");

        // 30 degrees, then ack together with a new start.
        run_op("b2b1", 32'h41F0_0000, 3'b001, 16'h2183, 16'h2000, 16'h376D);
        cmd_ack = 1'b1; cmd_start = 1'b1; cmd_angle = 32'hC307_0000;
        step();
        cmd_ack = 1'b0; cmd_start = 1'b0;
        chk("acks_busy", 32'(busy), 32'd0);
        chk("acks_done", 32'(done), 32'd0);
        step();
        chk("acks_no_start", 32'(norm_start), 32'd0);
        chk("acks_busy2", 32'(busy), 32'd0);
        chk("acks_norm_angle", norm_angle, 32'h41F0_0000);
        chk("acks_res_keep", 32'(res_sin), 32'h2000);

        // -135 degrees, reissued in IDLE.
        run_op("b2b2", 32'hC307_0000, 3'b110, 16'hD555, 16'hD2BF, 16'hD2BE);
        ack_op("b2b2");

        // Asynchronous reset while in CORDIC_WAIT.
        cmd_angle = 32'h3F80_0000; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0; norm_valid = 1'b1; norm_flip = 3'b000; norm_angle_fx = 16'h0072;
        step(); step();
        norm_valid = 1'b0;
        step();
        chk("ar_pre_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_norm_angle", norm_angle, 32'h0);
        chk("ar_cordic_angle", 32'(cordic_angle), 32'h0);
        chk("ar_res_sin", 32'(res_sin), 32'h0);
        chk("ar_res_flip", 32'(res_flip), 32'h0);
        step(); step();
        rst = 1'b1;
        step();
        run_op("post_rst", 32'h3F80_0000, 3'b010, 16'h0072, 16'h011E, 16'h3FF6);
        ack_op("post_rst");

`ifdef SEQ_WATCHDOG_EN
        // Normalizer never answers: timeout 10 cycles after NORM_WAIT entry.
        cmd_angle = 32'h4334_0000; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        step();
        for (int i = 0; i < 9; i++) step();
        chk("wd_not_yet", 32'(done), 32'd0);
        step();
        chk("wd_done", 32'(done), 32'd1);
        chk("wd_err", 32'(err), 32'd1);
        chk("wd_res_sin", 32'(res_sin), 32'h011E);
        chk("wd_res_cos", 32'(res_cos), 32'h3FF6);
        chk("wd_res_flip", 32'(res_flip), 32'h2);
        ack_op("wd");
`else
        // Without the watchdog the WAIT state holds indefinitely.
        cmd_angle = 32'h4334_0000; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        for (int i = 0; i < 250; i++) step();
        chk("nowd_done", 32'(done), 32'd0);
        chk("nowd_busy", 32'(busy), 32'd1);
        chk("nowd_err", 32'(err), 32'd0);
        norm_valid = 1'b1; norm_flip = 3'b101; norm_angle_fx = 16'h0000;
        step();
        norm_valid = 1'b0;
        step();
        cordic_done = 1'b1; cordic_sin = 16'h0000; cordic_cos = 16'h4000;
        step();
        cordic_done = 1'b0;
        chk("nowd_late_done", 32'(done), 32'd1);
        chk("nowd_late_flip", 32'(res_flip), 32'h5);
        ack_op("nowd");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
